// File: rtl/iram_stack_unit_pkg.sv
// Shared types and helpers for the internal data RAM and its stack engine.
package iram_pkg;

    // Stack sequencer states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P_LO = 3'd1,
        P_HI = 3'd2,
        Q_HI = 3'd3,
        Q_LO = 3'd4,
        DONE = 3'd5
    } stk_state_t;

    // Stack pointer value after reset on a classic 8051.
    localparam logic [7:0] SP_RESET_DEFAULT = 8'h07;

    // Address of Rn inside the selected register bank (banks are 8 bytes at 0x00-0x1F).
    function automatic logic [7:0] rn_addr(input logic [1:0] bank, input logic [2:0] sel);
        return {3'b000, bank, sel};
    endfunction

endpackage

// File: rtl/iram_stack_unit_if.sv
// Bus between decode/execute (master) and the internal data RAM (slave).
interface iram_stack_unit_if #(
    parameter int ADDR_W = 8
);
    // General and register-window read port.
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              reg_rd_en;
    logic [2:0]        reg_rd_sel;
    logic [7:0]        rd_data;
    logic              rd_valid;

    // General and register-window write port.
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              reg_wr_en;
    logic [2:0]        reg_wr_sel;
    logic [1:0]        bank_sel;

    // Stack pointer access.
    logic              sp_wr_en;
    logic [ADDR_W-1:0] sp_wr_data;
    logic [ADDR_W-1:0] sp;

    // Push/pop sequencer.
    logic              push_req;
    logic              pop_req;
    logic              stk_two;
    logic [15:0]       push_data;
    logic [15:0]       pop_data;
    logic              stk_busy;
    logic              stk_done;
    logic              stk_ovf;
    logic              stk_unf;
    logic              flag_clr;

    modport master (
        output rd_en, rd_addr, reg_rd_en, reg_rd_sel,
        output wr_en, wr_addr, wr_data, reg_wr_en, reg_wr_sel, bank_sel,
        output sp_wr_en, sp_wr_data,
        output push_req, pop_req, stk_two, push_data, flag_clr,
        input  rd_data, rd_valid, sp, pop_data, stk_busy, stk_done, stk_ovf, stk_unf
    );

    modport slave (
        input  rd_en, rd_addr, reg_rd_en, reg_rd_sel,
        input  wr_en, wr_addr, wr_data, reg_wr_en, reg_wr_sel, bank_sel,
        input  sp_wr_en, sp_wr_data,
        input  push_req, pop_req, stk_two, push_data, flag_clr,
        output rd_data, rd_valid, sp, pop_data, stk_busy, stk_done, stk_ovf, stk_unf
    );

endinterface

// File: rtl/iram_stack_unit_ctrl.sv
// Stack engine: sequencer FSM, stack pointer, sticky flags and pop result.
// Issues one write request and one read address per cycle into the RAM array.
module iram_stack_ctrl
    import iram_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(SP_RESET_DEFAULT)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push_req_i,
    input  logic              pop_req_i,
    input  logic              stk_two_i,
    input  logic [15:0]       push_data_i,
    input  logic              sp_wr_en_i,
    input  logic [ADDR_W-1:0] sp_wr_data_i,
    input  logic              flag_clr_i,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic [7:0]        mem_rd_data_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [7:0]        mem_wdata_o,
    output logic [ADDR_W-1:0] sp_o,
    output logic [15:0]       pop_data_o,
    output logic              stk_busy_o,
    output logic              stk_done_o,
    output logic              stk_ovf_o,
    output logic              stk_unf_o
);

    stk_state_t        state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [15:0]       data_q, data_d;
    logic              two_q, two_d;
    logic [15:0]       pop_q, pop_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] sp_inc;
    logic [ADDR_W-1:0] sp_dec;

    assign sp_inc = sp_q + 1'b1;
    assign sp_dec = sp_q - 1'b1;

    // Pops read the byte at the current SP.
    assign mem_rd_addr_o = sp_q;

    assign sp_o       = sp_q;
    assign pop_data_o = pop_q;
    assign stk_busy_o = (state_q != IDLE);
    assign stk_done_o = (state_q == DONE);
    assign stk_ovf_o  = ovf_q;
    assign stk_unf_o  = unf_q;

    // Next-state, pointer/flag update and memory request for the sequencer.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (which would infer a latch).
        state_d     = state_q;
        sp_d        = sp_q;
        data_d      = data_q;
        two_d       = two_q;
        pop_d       = pop_q;
        ovf_d       = flag_clr_i ? 1'b0 : ovf_q;
        unf_d       = flag_clr_i ? 1'b0 : unf_q;
        mem_we_o    = 1'b0;
        mem_waddr_o = sp_inc;
        mem_wdata_o = data_q[7:0];

        unique case (state_q)
            IDLE: begin
                if (push_req_i) begin
                    // Push wins over a simultaneous pop.
                    state_d = P_LO;
                    data_d  = push_data_i;
                    two_d   = stk_two_i;
                end else if (pop_req_i) begin
                    state_d = stk_two_i ? Q_HI : Q_LO;
                    two_d   = stk_two_i;
                end else if (sp_wr_en_i) begin
                    sp_d = sp_wr_data_i;
                end
            end
            P_LO: begin
                mem_we_o    = 1'b1;
                mem_wdata_o = data_q[7:0];
                sp_d        = sp_inc;
                if (sp_q == '1) ovf_d = 1'b1;
                state_d = two_q ? P_HI : DONE;
            end
            P_HI: begin
                mem_we_o    = 1'b1;
                mem_wdata_o = data_q[15:8];
                sp_d        = sp_inc;
                if (sp_q == '1) ovf_d = 1'b1;
                state_d = DONE;
            end
            Q_HI: begin
                pop_d[15:8] = mem_rd_data_i;
                sp_d        = sp_dec;
                if (sp_q == SP_RESET) unf_d = 1'b1;
                state_d = Q_LO;
            end
            Q_LO: begin
                // A single-byte pop returns a zero-extended byte.
                pop_d   = {(two_q ? pop_q[15:8] : 8'h00), mem_rd_data_i};
                sp_d    = sp_dec;
                if (sp_q == SP_RESET) unf_d = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state, pointer, flags and latched operands.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            sp_q    <= SP_RESET;
            data_q  <= '0;
            two_q   <= 1'b0;
            pop_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            data_q  <= data_d;
            two_q   <= two_d;
            pop_q   <= pop_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

endmodule

// File: rtl/iram_stack_unit.sv
// 8051 internal data RAM with register-bank window, SFR-visible SP and a
// hardware push/pop engine. One write and one registered read per cycle.
module iram_stack_unit
    import iram_pkg::*;
#(
    parameter int                ADDR_W         = 8,
    parameter logic [ADDR_W-1:0] SP_RESET       = ADDR_W'(SP_RESET_DEFAULT),
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    iram_stack_unit_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0]        mem_q [DEPTH];

    logic [ADDR_W-1:0] stk_rd_addr;
    logic [7:0]        stk_rd_data;
    logic              stk_we;
    logic [ADDR_W-1:0] stk_waddr;
    logic [7:0]        stk_wdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

    logic [ADDR_W-1:0] rd_addr_sel;
    logic              rd_fire;
    logic [7:0]        rd_data_q;
    logic              rd_valid_q;

    iram_stack_ctrl #(
        .ADDR_W   (ADDR_W),
        .SP_RESET (SP_RESET)
    ) u_ctrl (
        .clock         (clock),
        .reset         (reset),
        .push_req_i    (bus.push_req),
        .pop_req_i     (bus.pop_req),
        .stk_two_i     (bus.stk_two),
        .push_data_i   (bus.push_data),
        .sp_wr_en_i    (bus.sp_wr_en),
        .sp_wr_data_i  (bus.sp_wr_data),
        .flag_clr_i    (bus.flag_clr),
        .mem_rd_addr_o (stk_rd_addr),
        .mem_rd_data_i (stk_rd_data),
        .mem_we_o      (stk_we),
        .mem_waddr_o   (stk_waddr),
        .mem_wdata_o   (stk_wdata),
        .sp_o          (bus.sp),
        .pop_data_o    (bus.pop_data),
        .stk_busy_o    (bus.stk_busy),
        .stk_done_o    (bus.stk_done),
        .stk_ovf_o     (bus.stk_ovf),
        .stk_unf_o     (bus.stk_unf)
    );

    // Combinational array read for the stack engine.
    assign stk_rd_data = mem_q[stk_rd_addr];

    // Single write port arbitration: stack engine, then register window, then general write.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (stk_we) begin
            mem_we    = 1'b1;
            mem_waddr = stk_waddr;
            mem_wdata = stk_wdata;
        end else if (bus.reg_wr_en) begin
            mem_we    = 1'b1;
            mem_waddr = ADDR_W'(rn_addr(bus.bank_sel, bus.reg_wr_sel));
            mem_wdata = bus.wr_data;
        end else if (bus.wr_en) begin
            mem_we    = 1'b1;
            mem_waddr = bus.wr_addr;
            mem_wdata = bus.wr_data;
        end
    end

    // Array write, with optional clear on reset.
    always_ff @(posedge clock) begin
        // NOTE: the array is cleared only when CLEAR_ON_RESET is set; otherwise it carries no reset so it can map onto a plain RAM.
        if (reset) begin
            if (CLEAR_ON_RESET) begin
                for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Read address select: register window beats the general address.
    always_comb begin
        rd_addr_sel = bus.rd_addr;
        if (bus.reg_rd_en) rd_addr_sel = ADDR_W'(rn_addr(bus.bank_sel, bus.reg_rd_sel));
    end

    assign rd_fire = bus.reg_rd_en | bus.rd_en;

    // Registered read port; same-cycle write to the same address returns the old byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) rd_data_q <= mem_q[rd_addr_sel];
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_iram_stack_unit.sv
// Directed self-checking bench for iram_stack_unit.
module tb_iram_stack_unit;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;

    iram_stack_unit_if #(.ADDR_W(8)) bus ();

    iram_stack_unit #(
        .ADDR_W         (8),
        .SP_RESET       (8'h07),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
        bus.reg_rd_en  = 1'b0;
        bus.reg_rd_sel = '0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.reg_wr_en  = 1'b0;
        bus.reg_wr_sel = '0;
        bus.bank_sel   = '0;
        bus.sp_wr_en   = 1'b0;
        bus.sp_wr_data = '0;
        bus.push_req   = 1'b0;
        bus.pop_req    = 1'b0;
        bus.stk_two    = 1'b0;
        bus.push_data  = '0;
        bus.flag_clr   = 1'b0;
    endtask

    task automatic read_byte(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr;
        tick();
        bus.rd_en   = 1'b0;
        check({tag, "_data"}, 32'(bus.rd_data), 32'(exp));
        check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
    endtask

    task automatic write_byte(input logic [7:0] addr, input logic [7:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_sp", 32'(bus.sp), 32'h07);
        check("rst_rd_data", 32'(bus.rd_data), 32'h00);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_pop_data", 32'(bus.pop_data), 32'h0000);
        check("rst_busy", 32'(bus.stk_busy), 32'd0);
        check("rst_done", 32'(bus.stk_done), 32'd0);
        check("rst_ovf", 32'(bus.stk_ovf), 32'd0);
        check("rst_unf", 32'(bus.stk_unf), 32'd0);
        reset = 1'b0;

        // Register-window write: bank 2, R3 -> address 0x13
        bus.reg_wr_en  = 1'b1;
        bus.bank_sel   = 2'd2;
        bus.reg_wr_sel = 3'd3;
        bus.wr_data    = 8'hA5;
        tick();
        clear_inputs();
        read_byte("rn_wr_rd13", 8'h13, 8'hA5);
        tick();
        check("rd_valid_drop", 32'(bus.rd_valid), 32'd0);
        check("rd_data_hold", 32'(bus.rd_data), 32'hA5);

        // Register-window read beats general read
        bus.reg_rd_en  = 1'b1;
        bus.bank_sel   = 2'd2;
        bus.reg_rd_sel = 3'd3;
        bus.rd_en      = 1'b1;
        bus.rd_addr    = 8'h00;
        tick();
        clear_inputs();
        check("reg_rd_prio", 32'(bus.rd_data), 32'hA5);

        // Same-address read and write return the old byte
        bus.wr_en   = 1'b1;
        bus.wr_addr = 8'h13;
        bus.wr_data = 8'h5C;
        bus.rd_en   = 1'b1;
        bus.rd_addr = 8'h13;
        tick();
        clear_inputs();
        check("rw_same_old", 32'(bus.rd_data), 32'hA5);
        read_byte("rw_same_new", 8'h13, 8'h5C);

        // 16-bit push 0x1234 from SP=07
        bus.push_req  = 1'b1;
        bus.stk_two   = 1'b1;
        bus.push_data = 16'h1234;
        tick();
        clear_inputs();
        check("push16_c1_busy", 32'(bus.stk_busy), 32'd1);
        check("push16_c1_done", 32'(bus.stk_done), 32'd0);
        tick();
        check("push16_c2_sp", 32'(bus.sp), 32'h08);
        check("push16_c2_done", 32'(bus.stk_done), 32'd0);
        tick();
        check("push16_c3_done", 32'(bus.stk_done), 32'd1);
        check("push16_c3_sp", 32'(bus.sp), 32'h09);
        tick();
        check("push16_idle_done", 32'(bus.stk_done), 32'd0);
        check("push16_idle_busy", 32'(bus.stk_busy), 32'd0);
        read_byte("push16_m08", 8'h08, 8'h34);
        read_byte("push16_m09", 8'h09, 8'h12);

        // 16-bit pop back
        bus.pop_req = 1'b1;
        bus.stk_two = 1'b1;
        tick();
        clear_inputs();
        tick();
        check("pop16_c2_done", 32'(bus.stk_done), 32'd0);
        tick();
        check("pop16_c3_done", 32'(bus.stk_done), 32'd1);
        check("pop16_data", 32'(bus.pop_data), 32'h1234);
        check("pop16_sp", 32'(bus.sp), 32'h07);
        check("pop16_unf", 32'(bus.stk_unf), 32'd0);
        tick();

        // 8-bit pop at the floor: underflow, still completes
        write_byte(8'h07, 8'h77);
        bus.pop_req = 1'b1;
        bus.stk_two = 1'b0;
        tick();
        clear_inputs();
        tick();
        check("pop8_done", 32'(bus.stk_done), 32'd1);
        check("pop8_data", 32'(bus.pop_data), 32'h0077);
        check("pop8_sp", 32'(bus.sp), 32'h06);
        check("pop8_unf", 32'(bus.stk_unf), 32'd1);
        tick();
        check("unf_sticky", 32'(bus.stk_unf), 32'd1);
        bus.flag_clr = 1'b1;
        tick();
        bus.flag_clr = 1'b0;
        check("unf_clr", 32'(bus.stk_unf), 32'd0);

        // SP load to 0xFF, then 8-bit push wraps and sets overflow
        bus.sp_wr_en   = 1'b1;
        bus.sp_wr_data = 8'hFF;
        tick();
        clear_inputs();
        check("sp_load", 32'(bus.sp), 32'hFF);
        bus.push_req  = 1'b1;
        bus.stk_two   = 1'b0;
        bus.push_data = 16'hC35A;
        tick();
        clear_inputs();
        // SP load while busy is ignored; flag_clr loses to a same-cycle set
        bus.sp_wr_en   = 1'b1;
        bus.sp_wr_data = 8'h40;
        bus.flag_clr   = 1'b1;
        tick();
        clear_inputs();
        check("ovf_done", 32'(bus.stk_done), 32'd1);
        check("ovf_sp_wrap", 32'(bus.sp), 32'h00);
        check("ovf_set_wins", 32'(bus.stk_ovf), 32'd1);
        tick();
        read_byte("ovf_m00", 8'h00, 8'h5A);
        check("ovf_sticky", 32'(bus.stk_ovf), 32'd1);

        // Push + pop + general write together at 0x09
        bus.sp_wr_en   = 1'b1;
        bus.sp_wr_data = 8'h08;
        tick();
        clear_inputs();
        check("sp_load08", 32'(bus.sp), 32'h08);
        bus.push_req   = 1'b1;
        bus.pop_req    = 1'b1;
        bus.stk_two    = 1'b0;
        bus.push_data  = 16'h00EE;
        bus.wr_en      = 1'b1;
        bus.wr_addr    = 8'h09;
        bus.wr_data    = 8'hBB;
        bus.sp_wr_en   = 1'b1;
        bus.sp_wr_data = 8'h30;
        tick();
        bus.sp_wr_en = 1'b0;
        tick();
        clear_inputs();
        check("combo_done", 32'(bus.stk_done), 32'd1);
        check("combo_sp", 32'(bus.sp), 32'h09);
        check("combo_pop_kept", 32'(bus.pop_data), 32'h0077);
        tick();
        read_byte("combo_m09", 8'h09, 8'hEE);

        // Reset during P_HI
        write_byte(8'h20, 8'h66);
        bus.push_req  = 1'b1;
        bus.stk_two   = 1'b1;
        bus.push_data = 16'hABCD;
        tick();
        clear_inputs();
        tick();
        check("midrst_phi_sp", 32'(bus.sp), 32'h0A);
        check("midrst_phi_busy", 32'(bus.stk_busy), 32'd1);
        reset = 1'b1;
        tick();
        check("midrst_sp", 32'(bus.sp), 32'h07);
        check("midrst_busy", 32'(bus.stk_busy), 32'd0);
        check("midrst_done", 32'(bus.stk_done), 32'd0);
        check("midrst_ovf", 32'(bus.stk_ovf), 32'd0);
        reset = 1'b0;
        tick();
        check("midrst_done_after", 32'(bus.stk_done), 32'd0);
        check("midrst_sp_after", 32'(bus.sp), 32'h07);
        read_byte("midrst_m0a", 8'h0A, 8'h00);
        read_byte("midrst_m20", 8'h20, 8'h00);
        read_byte("midrst_m13", 8'h13, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
